// File: rtl/instr_mem_loadable_pkg.sv
// rtl/instr_mem_loadable_pkg.sv - shared state encoding, NOP word and index-width helper
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD = 32'h0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_mem_loadable_if.sv
// rtl/instr_mem_loadable_if.sv - load port and fetch port bundle
interface instr_mem_loadable_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PL_W   = 6
);
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              fetch_err;
  logic [PL_W-1:0]   prog_len;
  logic              state_run;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
    input  ld_ready, instr, instr_valid, fetch_err, prog_len, state_run
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
    output ld_ready, instr, instr_valid, fetch_err, prog_len, state_run
  );
endinterface

// File: rtl/instr_mem_loadable_ram.sv
// rtl/instr_mem_loadable_ram.sv - 1 write / 1 registered read word RAM
module imem_ram_1r1w
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    // read port holds its word while not enabled so the fetch output can hold
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - self-clearing, stream-loadable instruction memory with checked fetches
module instr_mem_loadable
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input logic                 i_clk,
  input logic                 i_rst,
  instr_mem_loadable_if.slave bus
);
  localparam int IDX_W = clog2(DEPTH);
  localparam int PL_W  = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_cptr;
  logic [IDX_W-1:0]  r_wptr;
  logic [PL_W-1:0]   r_prog_len;
  logic              r_ld_ready;
  logic              r_state_run;
  logic              r_instr_valid;
  logic              r_fetch_err;
  logic              r_nop;

  logic              w_run;
  logic              w_beat;
  logic              w_misalign;
  logic              w_oor;
  logic              w_fetch_ok;
  logic [ADDR_W-1:0] w_hi;
  logic [IDX_W-1:0]  w_idx;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  assign w_run      = (r_state == ST_RUN);
  assign w_beat     = r_ld_ready && bus.ld_valid;
  assign w_hi       = bus.fetch_addr >> (IDX_W + 2);
  assign w_oor      = |w_hi;
  assign w_misalign = |bus.fetch_addr[1:0];
  assign w_idx      = bus.fetch_addr[IDX_W+1:2];
  assign w_fetch_ok = bus.fetch_req && w_run && !w_misalign && !w_oor;

  // clear and load share the single write port
  assign w_we    = (r_state == ST_CLEAR) || w_beat;
  assign w_waddr = (r_state == ST_CLEAR) ? r_cptr : r_wptr;
  assign w_wdata = (r_state == ST_CLEAR) ? DATA_W'(NOP_WORD) : bus.ld_data;

  imem_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_fetch_ok),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_CLEAR;
      r_cptr        <= '0;
      r_wptr        <= '0;
      r_prog_len    <= '0;
      r_ld_ready    <= 1'b0;
      r_state_run   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_nop         <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cptr <= r_cptr + 1'b1;
          if (r_cptr == LAST_IDX) begin
            r_state    <= ST_LOAD;
            r_wptr     <= '0;
            r_prog_len <= '0;
            r_ld_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            r_wptr     <= r_wptr + 1'b1;
            r_prog_len <= r_prog_len + 1'b1;
            if (bus.ld_last || r_wptr == LAST_IDX) begin
              r_state     <= ST_RUN;
              r_ld_ready  <= 1'b0;
              r_state_run <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.ld_start) begin
            r_state     <= ST_CLEAR;
            r_cptr      <= '0;
            r_prog_len  <= '0;
            r_state_run <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cptr  <= '0;
        end
      endcase

      r_instr_valid <= w_fetch_ok;
      r_fetch_err   <= bus.fetch_req && w_run && (w_misalign || w_oor);
      // any sampled request that is not served forces NOP; idle cycles hold
      if (bus.fetch_req) r_nop <= !w_fetch_ok;
    end
  end

  assign bus.instr       = r_nop ? DATA_W'(NOP_WORD) : w_rdata;
  assign bus.instr_valid = r_instr_valid;
  assign bus.fetch_err   = r_fetch_err;
  assign bus.ld_ready    = r_ld_ready;
  assign bus.prog_len    = r_prog_len;
  assign bus.state_run   = r_state_run;
endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised instruction memory for the single-cycle/multi-cycle MIPS datapath. It replaces the fixed, initial-block-programmed ROM with a RAM that clears itself after reset and accepts a program over a valid/ready load port. Once loaded, it serves registered, word-aligned fetches with error flags. It sits between the PC logic and the decoder.

## Interface

Parameters:
- `DATA_W`, default 32: instruction word width.
- `DEPTH`, default 32: number of words; must be a power of two and at least 2.
- `ADDR_W`, default 32: byte-address width of `fetch_addr`.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ld_start` in 1: pulse that requests a reload; honoured only in RUN.
- `ld_valid` in 1: load word present.
- `ld_data` in DATA_W: load word.
- `ld_last` in 1: marks the final load word; qualified by `ld_valid`.
- `ld_ready` out 1: load port can accept a word.
- `fetch_req` in 1: fetch request.
- `fetch_addr` in ADDR_W: byte address of the fetch.
- `instr` out DATA_W: fetched word; NOP (all zeros) when invalid or in error.
- `instr_valid` out 1: `instr` holds a successful fetch.
- `fetch_err` out 1: the sampled request was misaligned or out of range.
- `prog_len` out clog2(DEPTH)+1: number of words loaded.
- `state_run` out 1: high in RUN.

## Operation

- States are CLEAR, LOAD and RUN. `rst` forces CLEAR from any state, including mid-load or mid-fetch.
- CLEAR:
  - A clear pointer writes zero to word 0..DEPTH-1, one word per cycle.
  - After writing word DEPTH-1 the block moves to LOAD, with the write pointer at 0 and `prog_len` at 0.
- LOAD:
  - `ld_ready` = 1. A beat transfers when `ld_valid && ld_ready`.
  - Each beat writes `ld_data` to mem[wptr], then increments `wptr` and `prog_len`.
  - A beat with `ld_last`, or the beat that writes word DEPTH-1, moves the block to RUN.
  - No further beats are accepted after that; `ld_ready` drops in the next cycle.
  - Unwritten words remain zero (NOP).
- RUN:
  - `ld_ready` = 0. `ld_start` moves the block to CLEAR; memory contents and `prog_len` are lost.
  - In CLEAR and LOAD, `ld_start` is ignored.
- Fetch index is `fetch_addr[clog2(DEPTH)+1:2]`.
- A request is misaligned if `fetch_addr[1:0]` != 0.
- A request is out of range if any bit of `fetch_addr` at or above bit clog2(DEPTH)+2 is set.
- Either condition gives `fetch_err` = 1, `instr` = 0 and `instr_valid` = 0.
- A `fetch_req` outside RUN gives `instr` = 0, `instr_valid` = 0 and `fetch_err` = 0. The request is dropped, not queued.
- When `fetch_req` = 0, `instr_valid` and `fetch_err` are 0 and `instr` holds its last value.
- If `fetch_req` and `ld_start` are both high in RUN, the fetch returns pre-clear data. CLEAR starts next cycle.

## Timing

- Reset values: `instr` = 0, `instr_valid` = 0, `fetch_err` = 0, `ld_ready` = 0, `prog_len` = 0, `state_run` = 0. State is CLEAR with the clear pointer at 0.
- Reset deasserted at edge 0: clearing occupies edges 1..DEPTH. `ld_ready` = 1 from edge DEPTH onward.
- Load: a beat accepted at edge t is in memory at t. `prog_len` updates at t. On a final beat, `state_run` = 1 after t.
- Fetch latency is 1: a request sampled at edge t drives `instr`, `instr_valid` and `fetch_err` after t, valid for exactly one cycle.
- Back-to-back requests give one result per cycle; there are no stalls.
- A fetch sampled at the same edge as the final load beat is not served; RUN is not yet active.

## Structure

- Shared package `imem_pkg`:
  - state encoding (CLEAR = 2'd0, LOAD = 2'd1, RUN = 2'd2);
  - `NOP_WORD` = 32'h0;
  - the index-width function clog2.
- One natural sub-module: `imem_ram_1r1w`.
  - One synchronous write port, used by both clear and load through a mux.
  - One synchronous read port.
  - Parametrised on `DATA_W` and `DEPTH`.
- The FSM, pointers and error checks stay in the top level.

## Test plan

- Reset then idle, DEPTH = 32: `ld_ready` stays 0 for 32 cycles and rises at edge 32. All outputs are at reset values throughout. A fetch of 0x0 during CLEAR returns `instr_valid` = 0.
- Load three words ending with `ld_last`: 0x8C080000, 0x8C090001, 0x8C0C000B. Expect `prog_len` = 3 and `state_run` = 1. Fetch 0x8 returns 0x8C0C000B with `instr_valid` = 1. Fetch 0xC returns 0x0.
- Error fetches in RUN: 0x6 gives `fetch_err` = 1, `instr` = 0, `instr_valid` = 0. 0x80 (DEPTH = 32) gives the same. 0x7C gives a valid result.
- Load 32 words with `ld_last` never asserted: RUN is entered on beat 32 and `ld_ready` falls. A 33rd `ld_valid` is not accepted. Fetch 0x7C returns the 32nd word.
- Reload:
  - Fetch 0x0 with `ld_start` in the same cycle returns the old word 0.
  - The 32-cycle CLEAR then follows.
  - Load one word 0x12345678 with `ld_last`.
  - Fetch 0x4 returns 0 (old contents gone), and `prog_len` = 1.
- `rst` asserted after beat 2 of a load: the block returns to CLEAR with `prog_len` = 0 and `ld_ready` = 0. After the reload, fetch 0x4 returns 0.
